menu_input_controller: RTL and testbench

//  Upstream stage of the restaurant 7-seg display. Conditions the raw menu buttons and
//  the OPEN/ENABLE switches, and produces the latched menu code that the display consumes.

---
 rtl/menu_pkg.sv | 20 ++
 rtl/menu_input_controller_button_debouncer.sv | 51 +++++
 rtl/menu_input_controller.sv | 151 +++++++++++++++
 tb/tb_menu_input_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared definitions for the menu input controller.
//   MENU_W        width of the menu code driven to the display
//   MENU_*        menu item codes
//   menu_state_t  controller FSM states
package menu_pkg;

   localparam int unsigned MENU_W = 4;

   localparam logic [MENU_W-1:0] MENU_OPEN   = 4'd0;
   localparam logic [MENU_W-1:0] MENU_BURGER = 4'd1;
   localparam logic [MENU_W-1:0] MENU_PIZZA  = 4'd2;
   localparam logic [MENU_W-1:0] MENU_KACCHI = 4'd3;
   localparam logic [MENU_W-1:0] MENU_PASTA  = 4'd4;

   typedef enum logic {
      IDLE,
      SHOW
   } menu_state_t;

endpackage

// File: rtl/menu_input_controller_button_debouncer.sv
// Per-button conditioning: 2-flop synchroniser, counter debouncer, press edge.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   raw    raw asynchronous bouncy button
//   level  debounced button level
//   press  one-cycle pulse on a debounced rising edge (releases ignored)
module button_debouncer
   import menu_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync_1;
   logic          sync_2;
   logic          level_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= raw;
         sync_2  <= sync_1;
         level_q <= level;
         // Count consecutive cycles of disagreement; any agreement restarts it.
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync_2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/menu_input_controller.sv
// Conditions the menu buttons and OPEN/ENABLE switches and produces the latched
// menu code for the 7-seg display.
//   clk             100 MHz system clock
//   rst_n           asynchronous active-low reset
//   btnU/D/L/R      raw bouncy buttons (BURGER/PIZZA/KACCHI/PASTA)
//   sw15            raw OPEN(1)/CLOSE(0) switch
//   sw16            raw menu-enable switch
//   menu_select     latched menu code, 0 = OPEN/CLOSE
//   open_sync       synchronised sw15
//   scroll_restart  one-cycle pulse whenever menu_select is written
module menu_input_controller
   import menu_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned HOLD_CYCLES     = 500_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btnU,
   input  logic              btnD,
   input  logic              btnL,
   input  logic              btnR,
   input  logic              sw15,
   input  logic              sw16,
   output logic [MENU_W-1:0] menu_select,
   output logic              open_sync,
   output logic              scroll_restart
);

   localparam int unsigned TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   logic [3:0] raw_btn;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] accepted;

   assign raw_btn = {btnR, btnL, btnD, btnU};

   for (genvar i = 0; i < 4; i++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (raw_btn[i]),
         .level(btn_level[i]),
         .press(btn_press[i])
      );
   end

   // A press is only meaningful while its debounced level is high.
   assign accepted = btn_press & btn_level;

   logic sw15_s1, sw15_s2, sw16_s1, sw16_s2;
   logic en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw15_s1 <= 1'b0;
         sw15_s2 <= 1'b0;
         sw16_s1 <= 1'b0;
         sw16_s2 <= 1'b0;
      end else begin
         sw15_s1 <= sw15;
         sw15_s2 <= sw15_s1;
         sw16_s1 <= sw16;
         sw16_s2 <= sw16_s1;
      end
   end

   assign open_sync = sw15_s2;
   assign en        = sw15_s2 & sw16_s2;

   // Fixed priority U > D > L > R.
   logic              sel_valid;
   logic [MENU_W-1:0] sel_code;

   always_comb begin
      sel_valid = 1'b1;
      sel_code  = MENU_OPEN;
      if (accepted[0])      sel_code = MENU_BURGER;
      else if (accepted[1]) sel_code = MENU_PIZZA;
      else if (accepted[2]) sel_code = MENU_KACCHI;
      else if (accepted[3]) sel_code = MENU_PASTA;
      else                  sel_valid = 1'b0;
   end

   menu_state_t       state_q, state_d;
   logic [MENU_W-1:0] menu_q, menu_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              scroll_q, scroll_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         menu_q   <= '0;
         timer_q  <= '0;
         scroll_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         menu_q   <= menu_d;
         timer_q  <= timer_d;
         scroll_q <= scroll_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      menu_d   = menu_q;
      timer_d  = timer_q;
      scroll_d = 1'b0;
      if (!en) begin
         state_d  = IDLE;
         menu_d   = MENU_OPEN;
         timer_d  = '0;
         scroll_d = (menu_q != MENU_OPEN);
      end else if (sel_valid) begin
         // A press beats a simultaneous timeout.
         state_d  = SHOW;
         menu_d   = sel_code;
         timer_d  = '0;
         scroll_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               menu_d  = MENU_OPEN;
               timer_d = '0;
            end
            SHOW: begin
               if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                  state_d  = IDLE;
                  menu_d   = MENU_OPEN;
                  timer_d  = '0;
                  scroll_d = 1'b1;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               menu_d  = MENU_OPEN;
               timer_d = '0;
            end
         endcase
      end
   end

   assign menu_select    = menu_q;
   assign scroll_restart = scroll_q;

endmodule

// File: tb/tb_menu_input_controller.sv
// Bench for menu_input_controller with short debounce/hold times.
module tb_menu_input_controller;

   localparam int unsigned DB = 4;
   localparam int unsigned HC = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
   logic       sw15 = 1'b1, sw16 = 1'b1;
   logic [3:0] menu_select;
   logic       open_sync;
   logic       scroll_restart;

   int unsigned tests = 0;
   int unsigned fails = 0;

   always #5 clk = ~clk;

   menu_input_controller #(
      .DEBOUNCE_CYCLES(DB),
      .HOLD_CYCLES    (HC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btnU          (btnU),
      .btnD          (btnD),
      .btnL          (btnL),
      .btnR          (btnR),
      .sw15          (sw15),
      .sw16          (sw16),
      .menu_select   (menu_select),
      .open_sync     (open_sync),
      .scroll_restart(scroll_restart)
   );

   // Reference model: inputs seen two edges late; a button level follows its
   // synchronised value once the last DB samples all disagree with it.
   bit          b_s1[4], b_s2[4], b_lvl[4], b_prev[4];
   bit          hist[4][DB];
   int unsigned hfill[4];
   bit          w15_s1, w15_s2, w16_s1, w16_s2;
   int unsigned m_menu, m_age;
   bit          m_pulse, m_open;

   int unsigned edge_no = 0;
   int unsigned pulses[$];
   int unsigned pulse_menu[$];

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         b_s1[i] = 0; b_s2[i] = 0; b_lvl[i] = 0; b_prev[i] = 0; hfill[i] = 0;
      end
      w15_s1 = 0; w15_s2 = 0; w16_s1 = 0; w16_s2 = 0;
      m_menu = 0; m_age = 0; m_pulse = 0; m_open = 0;
   endfunction

   function automatic void model_edge();
      bit raw[4];
      bit en;
      bit all_diff;
      int unsigned sel;
      raw[0] = btnU; raw[1] = btnD; raw[2] = btnL; raw[3] = btnR;
      en  = w15_s2 && w16_s2;
      sel = 0;
      for (int i = 3; i >= 0; i--)
         if (b_lvl[i] && !b_prev[i]) sel = i + 1;
      m_pulse = 0;
      if (!en) begin
         m_pulse = (m_menu != 0);
         m_menu  = 0;
         m_age   = 0;
      end else if (sel != 0) begin
         m_menu  = sel;
         m_age   = 0;
         m_pulse = 1;
      end else if (m_menu != 0) begin
         if (m_age == HC - 1) begin
            m_menu  = 0;
            m_age   = 0;
            m_pulse = 1;
         end else begin
            m_age++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         b_prev[i] = b_lvl[i];
         for (int k = 0; k < DB - 1; k++) hist[i][k] = hist[i][k+1];
         hist[i][DB-1] = b_s2[i];
         if (hfill[i] < DB) hfill[i]++;
         if (hfill[i] == DB) begin
            all_diff = 1;
            for (int k = 0; k < DB; k++) if (hist[i][k] == b_lvl[i]) all_diff = 0;
            if (all_diff) b_lvl[i] = b_s2[i];
         end
         b_s2[i] = b_s1[i];
         b_s1[i] = raw[i];
      end
      w15_s2 = w15_s1; w15_s1 = sw15;
      w16_s2 = w16_s1; w16_s1 = sw16;
      m_open = w15_s2;
   endfunction

   task automatic tick();
      @(posedge clk);
      edge_no++;
      if (rst_n) model_edge();
      else model_reset();
      @(negedge clk);
      tests++;
      assert (menu_select === 4'(m_menu)) else begin
         fails++;
         $error("FAIL menu_select edge %0d: got %0d expected %0d", edge_no, menu_select, m_menu);
      end
      tests++;
      assert (scroll_restart === m_pulse) else begin
         fails++;
         $error("FAIL scroll_restart edge %0d: got %0b expected %0b", edge_no, scroll_restart, m_pulse);
      end
      tests++;
      assert (open_sync === m_open) else begin
         fails++;
         $error("FAIL open_sync edge %0d: got %0b expected %0b", edge_no, open_sync, m_open);
      end
      if (scroll_restart === 1'b1) begin
         pulses.push_back(edge_no);
         pulse_menu.push_back(int'(menu_select));
      end
   endtask

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int unsigned rel_pulse(input int unsigned n, input int unsigned t0);
      return (pulses.size() > n) ? pulses[n] - t0 : 0;
   endfunction

   function automatic int unsigned menu_at(input int unsigned n);
      return (pulse_menu.size() > n) ? pulse_menu[n] : 99;
   endfunction

   task automatic start_capture(output int unsigned t0);
      pulses.delete();
      pulse_menu.delete();
      t0 = edge_no;
   endtask

   initial begin
      int unsigned t0;
      logic [3:0]  bits;

      model_reset();
      #1;
      tests++;
      assert (menu_select === 4'd0 && scroll_restart === 1'b0 && open_sync === 1'b0) else begin
         fails++;
         $error("FAIL reset_state: got %0d/%0b/%0b expected 0/0/0", menu_select, scroll_restart, open_sync);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (4) tick();

      // Clean press, held: shown at +7, times out at +27.
      start_capture(t0);
      btnU = 1'b1;
      repeat (30) tick();
      check("t1_load_edge", rel_pulse(0, t0), 7);
      check("t1_load_menu", menu_at(0), 1);
      check("t1_timeout_edge", rel_pulse(1, t0), 27);
      check("t1_timeout_menu", menu_at(1), 0);
      check("t1_pulse_count", pulses.size(), 2);
      btnU = 1'b0;
      repeat (10) tick();

      // Bouncing button: accepted 7 edges after the last transition.
      start_capture(t0);
      for (int i = 0; i < 8; i++) begin
         btnD = ~btnD;
         tick();
      end
      check("t2_no_change_in_bounce", pulses.size(), 0);
      start_capture(t0);
      btnD = 1'b1;
      repeat (7) tick();
      check("t2_load_edge", rel_pulse(0, t0), 7);
      check("t2_load_menu", menu_at(0), 2);

      // In SHOW(2), a press accepted when the hold timer reads 10 reloads it.
      repeat (4) tick();
      start_capture(t0);
      btnL = 1'b1;
      repeat (30) tick();
      check("t4_reload_edge", rel_pulse(0, t0), 7);
      check("t4_reload_menu", menu_at(0), 3);
      check("t4_timeout_after_reload", rel_pulse(1, t0) - rel_pulse(0, t0), 20);
      btnD = 1'b0; btnL = 1'b0;
      repeat (10) tick();

      // Simultaneous U and R: U wins.
      start_capture(t0);
      btnU = 1'b1; btnR = 1'b1;
      repeat (30) tick();
      check("t3_priority_menu", menu_at(0), 1);
      check("t3_priority_edge", rel_pulse(0, t0), 7);
      check("t3_pulse_count", pulses.size(), 2);
      btnU = 1'b0; btnR = 1'b0;
      repeat (10) tick();

      // Disabled: presses discarded.
      sw16 = 1'b0;
      repeat (4) tick();
      start_capture(t0);
      btnU = 1'b1; btnD = 1'b1; btnL = 1'b1; btnR = 1'b1;
      repeat (20) tick();
      check("t5_disabled_pulses", pulses.size(), 0);
      btnU = 1'b0; btnD = 1'b0; btnL = 1'b0; btnR = 1'b0;
      repeat (10) tick();
      sw16 = 1'b1;
      repeat (4) tick();
      start_capture(t0);
      btnR = 1'b1;
      repeat (7) tick();
      check("t5_pasta_menu", menu_at(0), 4);
      repeat (2) tick();
      start_capture(t0);
      sw16 = 1'b0;
      repeat (6) tick();
      check("t5_disable_edge", rel_pulse(0, t0), 3);
      check("t5_disable_menu", menu_at(0), 0);
      check("t5_disable_count", pulses.size(), 1);
      btnR = 1'b0; sw16 = 1'b1;
      repeat (10) tick();

      // Asynchronous reset between edges while in SHOW.
      btnU = 1'b1;
      repeat (9) tick();
      check("t6_in_show", int'(menu_select), 1);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      assert (menu_select === 4'd0 && scroll_restart === 1'b0) else begin
         fails++;
         $error("FAIL t6_async_clear: got %0d/%0b expected 0/0", menu_select, scroll_restart);
      end
      model_reset();
      btnU = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      for (int r = 0; r < 2; r++) begin
         start_capture(t0);
         btnU = 1'b1;
         repeat (30) tick();
         check("t6_post_reset_load", rel_pulse(0, t0), 7);
         check("t6_post_reset_timeout", rel_pulse(1, t0), 27);
         btnU = 1'b0;
         repeat (10) tick();
      end

      // Random buttons and switches against the model.
      for (int c = 0; c < 900; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            bits = 4'($urandom_range(0, 15));
            btnU = bits[0]; btnD = bits[1]; btnL = bits[2]; btnR = bits[3];
         end
         if ($urandom_range(0, 70) == 0) sw16 = ~sw16;
         if ($urandom_range(0, 90) == 0) sw15 = ~sw15;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
